rx_demux: RTL
=============

// Module: rx_demux
// PURPOSE
//  Receive-side counterpart of the TX symbol mux. Takes the de-stripped byte stream plus data/control flag,
//  classifies control symbols into the same 4-bit code space the TX side uses, frames STP/SDP..END/EDB packets,
//  forwards payload bytes and detects COM-led SKP/FTS ordered sets. Sits between lane un-striping and data layer.
// PARAMETERS
//  K_COM 8'hBC; K_SKP 8'h1C; K_STP 8'hFB; K_SDP 8'h5C; K_END 8'hFD; K_EDB 8'hFE; K_FTS 8'h3C; K_IDL 8'h7C  control symbol values
//  MAX_LEN  16  max payload bytes per packet; LEN_W 5  width of pkt_len (must hold MAX_LEN)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      reset rst, synchronous, active-high
//  enb          in   1      input qualifier; 0 = no symbol this cycle
//  rx_in        in   8      received symbol
//  rx_valid_in  in   1      1 = data byte, 0 = control symbol (same polarity as TX tx_Valid)
//  rx_data      out  8      payload byte
//  rx_data_vld  out  1      rx_data valid strobe
//  sop          out  1      packet start strobe; pkt_type valid with it
//  pkt_type     out  1      0 = STP (TLP), 1 = SDP (DLLP); held until next sop
//  eop          out  1      packet end strobe; pkt_len, pkt_err valid with it
//  pkt_len      out  LEN_W  payload bytes in ended packet
//  pkt_err      out  1      ended packet bad (EDB, abort, empty, overflow)
//  ctrl_vld     out  1      a control symbol was decoded
//  ctrl_code    out  4      0 unused,1 COM,2 SKP,3 STP,4 SDP,5 END,6 EDB,7 FTS,8 IDL,15 unknown K
//  os_vld       out  1      ordered-set complete strobe
//  os_type      out  1      0 = SKP OS, 1 = FTS OS
//  os_len       out  3      symbols after COM, saturates at 7
//  stray        out  1      data byte received outside a packet (byte dropped)
// BEHAVIOUR
//  All outputs registered, 1 cycle after the accepted input (enb=1). Strobes are single-cycle.
//  Reset: state S_IDLE, all outputs 0, internal counters 0. Reset beats enb; mid-packet reset drops packet, no eop.
//  enb=0: state/counters hold, all strobes 0, data/level outputs hold.
//  Every control symbol: ctrl_vld=1, ctrl_code per table; non-matching control byte -> code 15.
//  FSM S_IDLE:
//   data -> stray=1, byte dropped. STP/SDP -> sop=1, pkt_type set, len=0, -> S_PKT.
//   COM -> os_cnt=0, -> S_OS. END/EDB/SKP/FTS/IDL/unknown -> no framing effect.
//  FSM S_PKT:
//   data, len<MAX_LEN -> rx_data_vld=1, len++.
//   data, len==MAX_LEN -> byte dropped, eop=1, pkt_err=1, pkt_len=MAX_LEN, -> S_IDLE.
//   END -> eop=1, pkt_len=len, pkt_err=(len==0), -> S_IDLE.
//   EDB -> eop=1, pkt_err=1, -> S_IDLE.
//   any other control (STP/SDP/COM/SKP/FTS/IDL/unknown) -> abort: eop=1, pkt_err=1, pkt_len=len;
//    COM additionally enters S_OS (os_cnt=0); all others -> S_IDLE (no new sop on STP/SDP).
//  FSM S_OS (after COM):
//   first symbol sets os_type: SKP -> 0, FTS -> 1; os_cnt=1. Further same-type symbols: os_cnt++ (sat 7).
//   any other symbol (incl. other-type K, COM, data) closes the set: if os_cnt>=1, os_vld=1, os_len=os_cnt;
//    the closing symbol is then processed exactly as in S_IDLE in the same cycle (COM restarts S_OS,
//    STP/SDP -> sop, data -> stray). COM then non-SKP/FTS: no os_vld.
//  Simultaneous strobes legal in one cycle: eop+ctrl_vld, os_vld+sop, os_vld+stray, os_vld+ctrl_vld.
//  rx_data_vld never coincides with sop or eop; sop never coincides with eop.
// TESTING
//  rst=1 two cycles, random rx_in -> all outputs 0, state S_IDLE.
//  STP,D 11,22,33,END -> sop(type 0); rx_data 11,22,33 on 3 cycles; eop len=3 err=0; ctrl_vld codes 3,5.
//  SDP,END -> sop(type 1), eop len=0 err=1. STP,D AA,EDB -> eop len=1 err=1.
//  STP + 17 data bytes (MAX_LEN=16) -> 16 rx_data_vld, eop len=16 err=1, byte 17 dropped; then D 55 -> stray=1.
//  COM,SKP,SKP,SKP,STP -> os_vld type 0 len 3 with sop same cycle; COM,FTS x9,IDL -> os_vld type 1 len 7.
//  STP,D 01,COM,SKP,IDL -> eop err=1 len=1, then os_vld len=1; enb=0 gaps inserted anywhere -> identical result.

Source files
------------

// File: rtl/rx_demux.sv
// Receive-side symbol demux: classifies control symbols, frames STP/SDP..END/EDB packets,
// forwards payload bytes and detects COM-led SKP/FTS ordered sets.
module rx_demux #(
  parameter logic [7:0]  K_COM   = 8'hBC,
  parameter logic [7:0]  K_SKP   = 8'h1C,
  parameter logic [7:0]  K_STP   = 8'hFB,
  parameter logic [7:0]  K_SDP   = 8'h5C,
  parameter logic [7:0]  K_END   = 8'hFD,
  parameter logic [7:0]  K_EDB   = 8'hFE,
  parameter logic [7:0]  K_FTS   = 8'h3C,
  parameter logic [7:0]  K_IDL   = 8'h7C,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [7:0]       rx_in,
  input  logic             rx_valid_in,
  output logic [7:0]       rx_data,
  output logic             rx_data_vld,
  output logic             sop,
  output logic             pkt_type,
  output logic             eop,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_err,
  output logic             ctrl_vld,
  output logic [3:0]       ctrl_code,
  output logic             os_vld,
  output logic             os_type,
  output logic [2:0]       os_len,
  output logic             stray
);

  localparam logic [3:0] CodeCom = 4'd1;
  localparam logic [3:0] CodeSkp = 4'd2;
  localparam logic [3:0] CodeStp = 4'd3;
  localparam logic [3:0] CodeSdp = 4'd4;
  localparam logic [3:0] CodeEnd = 4'd5;
  localparam logic [3:0] CodeEdb = 4'd6;
  localparam logic [3:0] CodeFts = 4'd7;
  localparam logic [3:0] CodeIdl = 4'd8;
  localparam logic [3:0] CodeUnk = 4'd15;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StPkt, StOs} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       os_cnt_q, os_cnt_d;
  logic             os_kind_q, os_kind_d;

  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_data_vld_q, rx_data_vld_d;
  logic             sop_q, sop_d;
  logic             pkt_type_q, pkt_type_d;
  logic             eop_q, eop_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             pkt_err_q, pkt_err_d;
  logic             ctrl_vld_q, ctrl_vld_d;
  logic [3:0]       ctrl_code_q, ctrl_code_d;
  logic             os_vld_q, os_vld_d;
  logic             os_type_q, os_type_d;
  logic [2:0]       os_len_q, os_len_d;
  logic             stray_q, stray_d;

  logic [3:0] code;
  logic       is_data, is_skp, is_fts, same_os, idle_proc;

  always_comb begin
    code = CodeUnk;
    case (rx_in)
      K_COM:   code = CodeCom;
      K_SKP:   code = CodeSkp;
      K_STP:   code = CodeStp;
      K_SDP:   code = CodeSdp;
      K_END:   code = CodeEnd;
      K_EDB:   code = CodeEdb;
      K_FTS:   code = CodeFts;
      K_IDL:   code = CodeIdl;
      default: code = CodeUnk;
    endcase
  end

  assign is_data = rx_valid_in;
  assign is_skp  = !is_data && (code == CodeSkp);
  assign is_fts  = !is_data && (code == CodeFts);
  assign same_os = os_kind_q ? is_fts : is_skp;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    os_cnt_d      = os_cnt_q;
    os_kind_d     = os_kind_q;
    rx_data_d     = rx_data_q;
    rx_data_vld_d = 1'b0;
    sop_d         = 1'b0;
    pkt_type_d    = pkt_type_q;
    eop_d         = 1'b0;
    pkt_len_d     = pkt_len_q;
    pkt_err_d     = pkt_err_q;
    ctrl_vld_d    = 1'b0;
    ctrl_code_d   = ctrl_code_q;
    os_vld_d      = 1'b0;
    os_type_d     = os_type_q;
    os_len_d      = os_len_q;
    stray_d       = 1'b0;
    idle_proc     = 1'b0;

    if (enb) begin
      if (!is_data) begin
        ctrl_vld_d  = 1'b1;
        ctrl_code_d = code;
      end

      unique case (state_q)
        StIdle: idle_proc = 1'b1;
        StPkt: begin
          if (is_data) begin
            if (len_q == MaxLen) begin
              eop_d     = 1'b1;
              pkt_err_d = 1'b1;
              pkt_len_d = MaxLen;
              state_d   = StIdle;
            end else begin
              rx_data_d     = rx_in;
              rx_data_vld_d = 1'b1;
              len_d         = len_q + LEN_W'(1);
            end
          end else begin
            // Every control symbol ends the packet; only END with payload is clean.
            eop_d     = 1'b1;
            pkt_len_d = len_q;
            pkt_err_d = (code == CodeEnd) ? (len_q == '0) : 1'b1;
            state_d   = StIdle;
            if (code == CodeCom) begin
              state_d  = StOs;
              os_cnt_d = 3'd0;
            end
          end
        end
        StOs: begin
          if (os_cnt_q == 3'd0 && (is_skp || is_fts)) begin
            os_kind_d = is_fts;
            os_cnt_d  = 3'd1;
          end else if (os_cnt_q != 3'd0 && same_os) begin
            if (os_cnt_q != 3'd7) os_cnt_d = os_cnt_q + 3'd1;
          end else begin
            if (os_cnt_q != 3'd0) begin
              os_vld_d  = 1'b1;
              os_type_d = os_kind_q;
              os_len_d  = os_cnt_q;
            end
            idle_proc = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      // Idle handling also applies to the symbol that closes an ordered set.
      if (idle_proc) begin
        state_d = StIdle;
        if (is_data) begin
          stray_d = 1'b1;
        end else if (code == CodeStp || code == CodeSdp) begin
          sop_d      = 1'b1;
          pkt_type_d = (code == CodeSdp);
          len_d      = '0;
          state_d    = StPkt;
        end else if (code == CodeCom) begin
          os_cnt_d = 3'd0;
          state_d  = StOs;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      len_q         <= '0;
      os_cnt_q      <= 3'd0;
      os_kind_q     <= 1'b0;
      rx_data_q     <= 8'd0;
      rx_data_vld_q <= 1'b0;
      sop_q         <= 1'b0;
      pkt_type_q    <= 1'b0;
      eop_q         <= 1'b0;
      pkt_len_q     <= '0;
      pkt_err_q     <= 1'b0;
      ctrl_vld_q    <= 1'b0;
      ctrl_code_q   <= 4'd0;
      os_vld_q      <= 1'b0;
      os_type_q     <= 1'b0;
      os_len_q      <= 3'd0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      os_cnt_q      <= os_cnt_d;
      os_kind_q     <= os_kind_d;
      rx_data_q     <= rx_data_d;
      rx_data_vld_q <= rx_data_vld_d;
      sop_q         <= sop_d;
      pkt_type_q    <= pkt_type_d;
      eop_q         <= eop_d;
      pkt_len_q     <= pkt_len_d;
      pkt_err_q     <= pkt_err_d;
      ctrl_vld_q    <= ctrl_vld_d;
      ctrl_code_q   <= ctrl_code_d;
      os_vld_q      <= os_vld_d;
      os_type_q     <= os_type_d;
      os_len_q      <= os_len_d;
      stray_q       <= stray_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_data_vld = rx_data_vld_q;
  assign sop         = sop_q;
  assign pkt_type    = pkt_type_q;
  assign eop         = eop_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_err     = pkt_err_q;
  assign ctrl_vld    = ctrl_vld_q;
  assign ctrl_code   = ctrl_code_q;
  assign os_vld      = os_vld_q;
  assign os_type     = os_type_q;
  assign os_len      = os_len_q;
  assign stray       = stray_q;

endmodule
